// File: rtl/axi4_rab_pkg.sv
// Shared RAB types and constants: AXI response codes, R-channel sender states
// and the drop request carried from the AR path to the R-channel sender.
package axi4_rab_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // RAB-wide ID/USER widths; the drop request struct is sized from these.
  localparam int RAB_ID_WIDTH   = 4;
  localparam int RAB_USER_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    ERR  = 2'd2
  } rdch_state_t;

  typedef struct packed {
    logic [RAB_ID_WIDTH-1:0]   id;
    logic [7:0]                len;
    logic [RAB_USER_WIDTH-1:0] user;
  } drop_req_t;

endpackage

// File: rtl/axi4_rdch_drop_fifo.sv
// Register FIFO of pending drop requests. push_ready depends only on occupancy,
// so a pop in the same cycle never frees a slot for a push while full.
module axi4_rdch_drop_fifo
  import axi4_rab_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_valid,
  input  drop_req_t push_data,
  output logic      push_ready,
  output logic      pop_valid,
  output drop_req_t pop_data,
  input  logic      pop_ready
);

  localparam logic [LOG_DEPTH:0]   FULL_CNT = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   ONE_CNT  = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH-1:0] LAST_PTR = LOG_DEPTH'(DEPTH-1);
  localparam logic [LOG_DEPTH-1:0] ONE_PTR  = LOG_DEPTH'(1);

  drop_req_t            mem_r [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_r;
  logic [LOG_DEPTH-1:0] rd_ptr_r;
  logic [LOG_DEPTH:0]   cnt_r;
  logic                 push_s;
  logic                 pop_s;

  assign push_ready = (cnt_r != FULL_CNT);
  assign pop_valid  = (cnt_r != {(LOG_DEPTH+1){1'b0}});
  assign pop_data   = mem_r[rd_ptr_r];
  assign push_s     = push_valid && push_ready;
  assign pop_s      = pop_valid && pop_ready;

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(drop_req_t){1'b0}};
      end
      wr_ptr_r <= {LOG_DEPTH{1'b0}};
      rd_ptr_r <= {LOG_DEPTH{1'b0}};
      cnt_r    <= {(LOG_DEPTH+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= (wr_ptr_r == LAST_PTR) ? {LOG_DEPTH{1'b0}} : wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {LOG_DEPTH{1'b0}} : rd_ptr_r + ONE_PTR;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + ONE_CNT;
        2'b01:   cnt_r <= cnt_r - ONE_CNT;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/axi4_rdch_sender_chk.sv
// Protocol checks around the R-channel sender's drop request interface.
module axi4_rdch_sender_chk (
  input logic clk,
  input logic rst_n,
  input logic drop_valid,
  input logic drop_ready
);

  // A dropped AR offered while the FIFO is full would be silently lost.
  drop_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    drop_valid |-> drop_ready);

endmodule

// File: rtl/axi4_rdch_sender.sv
// RAB R-channel return path: forwards master-port R bursts and synthesises
// SLVERR bursts for dropped reads, arbitrating whole bursts round-robin.
module axi4_rdch_sender
  import axi4_rab_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH    = 32,
  parameter int C_AXI_ID_WIDTH      = RAB_ID_WIDTH,
  parameter int C_AXI_USER_WIDTH    = RAB_USER_WIDTH,
  parameter int DROP_FIFO_DEPTH     = 4,
  parameter int LOG_DROP_FIFO_DEPTH = 2
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arstn,
  input  logic                        drop_valid,
  input  logic [C_AXI_ID_WIDTH-1:0]   drop_id,
  input  logic [7:0]                  drop_len,
  input  logic [C_AXI_USER_WIDTH-1:0] drop_user,
  output logic                        drop_ready,
  input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0] m_axi4_rdata,
  input  logic [1:0]                  m_axi4_rresp,
  input  logic                        m_axi4_rlast,
  input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_ruser,
  input  logic                        m_axi4_rvalid,
  output logic                        m_axi4_rready,
  output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_rid,
  output logic [C_AXI_DATA_WIDTH-1:0] s_axi4_rdata,
  output logic [1:0]                  s_axi4_rresp,
  output logic                        s_axi4_rlast,
  output logic [C_AXI_USER_WIDTH-1:0] s_axi4_ruser,
  output logic                        s_axi4_rvalid,
  input  logic                        s_axi4_rready
);

  rdch_state_t state_r;
  rdch_state_t state_nxt_s;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_nxt_s;
  logic        rr_last_err_r;
  logic        rr_last_err_nxt_s;
  drop_req_t   push_req_s;
  drop_req_t   head_s;
  logic        head_valid_s;
  logic        pop_s;

  assign push_req_s = '{id: drop_id, len: drop_len, user: drop_user};

  axi4_rdch_drop_fifo #(
    .DEPTH     (DROP_FIFO_DEPTH),
    .LOG_DEPTH (LOG_DROP_FIFO_DEPTH)
  ) u_drop_fifo (
    .clk        (axi4_aclk),
    .rst_n      (axi4_arstn),
    .push_valid (drop_valid),
    .push_data  (push_req_s),
    .push_ready (drop_ready),
    .pop_valid  (head_valid_s),
    .pop_data   (head_s),
    .pop_ready  (pop_s)
  );

  axi4_rdch_sender_chk u_chk (
    .clk        (axi4_aclk),
    .rst_n      (axi4_arstn),
    .drop_valid (drop_valid),
    .drop_ready (drop_ready)
  );

  // State, error beat counter and round-robin memory.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      state_r       <= IDLE;
      cnt_r         <= 8'd0;
      rr_last_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      rr_last_err_r <= rr_last_err_nxt_s;
    end
  end

  // Arbitration, error beat generation and slave-port muxing.
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = cnt_r;
    rr_last_err_nxt_s = rr_last_err_r;
    pop_s             = 1'b0;
    m_axi4_rready     = 1'b0;
    s_axi4_rvalid     = 1'b0;
    s_axi4_rid        = {C_AXI_ID_WIDTH{1'b0}};
    s_axi4_rdata      = {C_AXI_DATA_WIDTH{1'b0}};
    s_axi4_rresp      = RESP_OKAY;
    s_axi4_rlast      = 1'b0;
    s_axi4_ruser      = {C_AXI_USER_WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (head_valid_s && m_axi4_rvalid) begin
          state_nxt_s = rr_last_err_r ? FWD : ERR;
        end else if (head_valid_s) begin
          state_nxt_s = ERR;
        end else if (m_axi4_rvalid) begin
          state_nxt_s = FWD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FWD: begin
        s_axi4_rvalid = m_axi4_rvalid;
        s_axi4_rid    = m_axi4_rid;
        s_axi4_rdata  = m_axi4_rdata;
        s_axi4_rresp  = m_axi4_rresp;
        s_axi4_rlast  = m_axi4_rlast;
        s_axi4_ruser  = m_axi4_ruser;
        m_axi4_rready = s_axi4_rready;
        if (m_axi4_rvalid && s_axi4_rready && m_axi4_rlast) begin
          state_nxt_s       = IDLE;
          rr_last_err_nxt_s = 1'b0;
        end else begin
          state_nxt_s = FWD;
        end
      end
      ERR: begin
        // The head entry stays in the FIFO until its last beat, so the
        // payload is stable across backpressure regardless of new pushes.
        s_axi4_rvalid = 1'b1;
        s_axi4_rid    = head_s.id;
        s_axi4_rresp  = RESP_SLVERR;
        s_axi4_ruser  = head_s.user;
        s_axi4_rlast  = (cnt_r == head_s.len);
        if (s_axi4_rready) begin
          if (cnt_r == head_s.len) begin
            pop_s             = 1'b1;
            cnt_nxt_s         = 8'd0;
            rr_last_err_nxt_s = 1'b1;
            state_nxt_s       = IDLE;
          end else begin
            cnt_nxt_s = cnt_r + 8'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

endmodule
